// File: rtl/conv_accum.sv
// conv_accum: per-lane multiply-accumulate for the conv1 layer.
// Every lane multiplies its activation by one broadcast weight for TAPS taps,
// adds a bias on the final tap, then rescales and saturates to Q(16-FRAC_BITS).FRAC_BITS.
// Pipeline: stage 1 product register, stage 2 accumulator, output register.
// Optional feature macro: CONV_ACCUM_RELU_EN (clamp negative results to zero).
`ifndef MAC_NUM
`define MAC_NUM 112
`endif

module conv_accum #(
    parameter int FRAC_BITS = 8,
    parameter int TAPS      = 25
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [3:0]               cur_state,
    input  logic [`MAC_NUM*16-1:0]   input_buf,
    input  logic [15:0]              weight,
    input  logic [15:0]              bias,
    output logic [`MAC_NUM*16-1:0]   out_data,
    output logic                     out_valid,
    output logic                     busy
);
    localparam int LANES  = `MAC_NUM;
    localparam int DATA_W = 16;
    localparam int PROD_W = 32;
    localparam int ACC_W  = 40;
    localparam int CNT_W  = (TAPS > 1) ? $clog2(TAPS) : 1;

    localparam logic signed [ACC_W-1:0] ZERO_ACC = '0;
    localparam logic signed [ACC_W-1:0] MAX_V    = 40'sd32767;
    localparam logic signed [ACC_W-1:0] MIN_V    = -40'sd32768;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          tap_cnt;
    logic                      accept;
    logic                      last_tap;

    logic signed [PROD_W-1:0]  prod_p1 [LANES];
    logic                      vld_p1, first_p1, last_p1;
    logic signed [DATA_W-1:0]  bias_p1;
    logic signed [ACC_W-1:0]   bias_ext;

    logic signed [ACC_W-1:0]   acc_p2 [LANES];
    logic                      vld_p2;

    // Rescale by FRAC_BITS (arithmetic shift floors toward minus infinity) and clamp to 16 bits.
    function automatic logic signed [DATA_W-1:0] sat_shift(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0]  shifted;
        logic signed [DATA_W-1:0] res;
        shifted = acc >>> FRAC_BITS;
        if (shifted > MAX_V)
            res = 16'sh7FFF;
        else if (shifted < MIN_V)
            res = 16'sh8000;
        else
            res = DATA_W'(shifted);
        return res;
    endfunction

    // Optional rectification applied after saturation; identity in the default build.
    function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] v);
`ifdef CONV_ACCUM_RELU_EN
        return v[DATA_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign accept   = en && (cur_state == 4'd1);
    assign last_tap = (tap_cnt == CNT_W'(TAPS - 1));
    assign bias_ext = {{(ACC_W-DATA_W){bias_p1[DATA_W-1]}}, bias_p1} <<< FRAC_BITS;

    // Tap counter: position of the next accepted tap inside the current window.
    always_ff @(posedge clk) begin
        if (rst)
            tap_cnt <= '0;
        else if (accept)
            tap_cnt <= last_tap ? '0 : tap_cnt + CNT_W'(1);
    end

    // ---- stage 1: per-lane product of activation and broadcast weight ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
            bias_p1  <= '0;
            for (int i = 0; i < LANES; i++)
                prod_p1[i] <= '0;
        end else begin
            vld_p1   <= accept;
            first_p1 <= accept && (tap_cnt == '0);
            last_p1  <= accept && last_tap;
            if (accept && last_tap)
                bias_p1 <= bias;
            if (accept)
                for (int i = 0; i < LANES; i++)
                    prod_p1[i] <= $signed(input_buf[16*i +: 16]) * $signed(weight);
        end
    end

    // ---- stage 2: accumulate; tap 0 loads so windows never mix, final tap folds in the bias ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2 <= 1'b0;
            for (int i = 0; i < LANES; i++)
                acc_p2[i] <= '0;
        end else begin
            vld_p2 <= vld_p1 && last_p1;
            if (vld_p1)
                for (int i = 0; i < LANES; i++)
                    acc_p2[i] <= (first_p1 ? ZERO_ACC : acc_p2[i])
                               + {{(ACC_W-PROD_W){prod_p1[i][PROD_W-1]}}, prod_p1[i]}
                               + (last_p1 ? bias_ext : ZERO_ACC);
        end
    end

    // ---- output register: rescaled result held until the next completed window ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= vld_p2;
            if (vld_p2)
                for (int i = 0; i < LANES; i++)
                    out_data[16*i +: 16] <= relu(sat_shift(acc_p2[i]));
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state: any accepted tap keeps us accumulating (a tap in DRAIN starts the next window).
    always_comb begin
        state_nxt = state;
        if (accept)
            state_nxt = last_tap ? DRAIN : ACCUM;
        else if (state == DRAIN && vld_p2)
            state_nxt = IDLE;
    end

    // FSM outputs.
    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_conv_accum.sv
// Testbench for conv_accum: directed vector table, reset/back-to-back sequences,
// and randomized windows checked by a behavioural scoreboard.
`ifndef MAC_NUM
`define MAC_NUM 112
`endif

module tb_conv_accum;
  localparam int LANES = `MAC_NUM;
  localparam int FRAC  = 8;
  localparam int TAPS  = 25;
  localparam int W     = LANES * 16;

`ifdef CONV_ACCUM_RELU_EN
  localparam logic [15:0] E_NEG_SAT = 16'h0000;
  localparam logic [15:0] E_RAMP1   = 16'h0000;
  localparam logic [15:0] E_MINUS1  = 16'h0000;
`else
  localparam logic [15:0] E_NEG_SAT = 16'h8000;
  localparam logic [15:0] E_RAMP1   = 16'hE780;
  localparam logic [15:0] E_MINUS1  = 16'hFFFF;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [3:0]     cur_state;
  logic [W-1:0]   input_buf;
  logic [15:0]    weight;
  logic [15:0]    bias;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           busy;

  conv_accum #(.FRAC_BITS(FRAC), .TAPS(TAPS)) dut (
    .clk(clk), .rst(rst), .en(en), .cur_state(cur_state),
    .input_buf(input_buf), .weight(weight), .bias(bias),
    .out_data(out_data), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  int vcount = 0;
  logic [15:0] vals[$];

  function automatic void chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t   expq[$];
  longint sum[LANES];
  int     ntap = 0;

  function automatic logic [15:0] ref_out(input longint s);
    longint d, q;
    d = 64'sd1 << FRAC;
    q = s / d;
    if (s < 0 && q * d != s) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
`ifdef CONV_ACCUM_RELU_EN
    if (q < 0) q = 0;
`endif
    return 16'(q);
  endfunction

  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (rst) begin
      ntap = 0;
      expq.delete();
    end else if (en && cur_state == 4'd1) begin
      for (int i = 0; i < LANES; i++) begin
        if (ntap == 0) sum[i] = 0;
        sum[i] += longint'($signed(input_buf[16*i +: 16])) * longint'($signed(weight));
      end
      ntap++;
      if (ntap == TAPS) begin
        for (int i = 0; i < LANES; i++)
          e.data[16*i +: 16] = ref_out(sum[i] + longint'($signed(bias)) * (64'sd1 << FRAC));
        e.due = cyc + 2;
        expq.push_back(e);
        ntap = 0;
      end
    end
  end

  // Scoreboard / output monitor, sampled on the falling edge.
  logic [W-1:0] held = '0;
  always @(negedge clk) begin
    exp_t e;
    int   bad;
    if (rst) begin
      held = '0;
    end else begin
      if (expq.size() > 0 && expq[0].due < cyc) begin
        checks++;
        $display("FAIL sb_missing: no out_valid at cycle %0d, required by cycle %0d", cyc, expq[0].due);
        void'(expq.pop_front());
      end
      if (out_valid) begin
        vcount++;
        vals.push_back(out_data[15:0]);
        if (expq.size() == 0) begin
          checks++;
          $display("FAIL sb_unexpected: out_valid=1 at cycle %0d, required 0", cyc);
        end else begin
          e = expq.pop_front();
          chk("sb_timing", cyc, e.due);
          bad = -1;
          for (int i = 0; i < LANES; i++)
            if (bad < 0 && out_data[16*i +: 16] !== e.data[16*i +: 16]) bad = i;
          checks++;
          if (bad < 0) passes++;
          else $display("FAIL sb_data lane %0d: got %h expected %h", bad,
                        out_data[16*bad +: 16], e.data[16*bad +: 16]);
        end
        held = out_data;
      end else begin
        checks++;
        if (out_data === held) passes++;
        else $display("FAIL hold: out_data changed without out_valid at cycle %0d", cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tap(input logic [3:0] st);
    en = 1'b1;
    cur_state = st;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_const(input logic [15:0] v);
    for (int i = 0; i < LANES; i++) input_buf[16*i +: 16] = v;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < LANES; i++) input_buf[16*i +: 16] = 16'(i << 8);
  endtask

  // One full window; noisy inserts gaps and ignored cur_state=2 taps, rnd randomizes data.
  task automatic window(input logic [15:0] w, input bit noisy, input bit rnd);
    for (int t = 0; t < TAPS; t++) begin
      if (noisy && t > 0) begin
        repeat ($urandom_range(0, 3)) begin
          if ($urandom_range(0, 1) == 1) begin
            weight = 16'h7FFF;
            tap(4'd2);
          end else begin
            idle(1);
          end
        end
      end
      if (rnd) begin
        for (int i = 0; i < LANES; i++) input_buf[16*i +: 16] = 16'($urandom);
        weight = 16'($urandom);
        bias   = 16'($urandom);
      end else begin
        weight = w;
      end
      tap(4'd1);
    end
  endtask

  // Waits (bounded) for out_valid after the final tap; latency counts the accepting edge.
  task automatic wait_valid(input string nm, input int acc_cyc);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_lat"}, cyc - acc_cyc + 1, 3);
  endtask

  typedef struct {
    bit          ramp;
    logic [15:0] act, w, b;
    logic [15:0] e0, e1, elast;
  } vec_t;

  vec_t vt[6];

  initial begin
    int acc_cyc, v0, n0;

    vt[0] = '{1'b0, 16'h0100, 16'h0100, 16'h0000, 16'h1900, 16'h1900, 16'h1900};
    vt[1] = '{1'b0, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    vt[2] = '{1'b0, 16'h8000, 16'h7FFF, 16'h0000, E_NEG_SAT, E_NEG_SAT, E_NEG_SAT};
    vt[3] = '{1'b1, 16'h0000, 16'hFF00, 16'h0080, 16'h0080, E_RAMP1, E_NEG_SAT};
    vt[4] = '{1'b0, 16'h0100, 16'h0100, 16'hFF00, 16'h1800, 16'h1800, 16'h1800};
    vt[5] = '{1'b0, 16'h0001, 16'hFFFF, 16'h0000, E_MINUS1, E_MINUS1, E_MINUS1};

    rst = 1'b1; en = 1'b0; cur_state = 4'd0;
    input_buf = '0; weight = '0; bias = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data_nonzero", (out_data != '0) ? 1 : 0, 0);

    // Directed vector table.
    for (int k = 0; k < 6; k++) begin
      if (vt[k].ramp) set_ramp(); else set_const(vt[k].act);
      bias = vt[k].b;
      for (int t = 0; t < TAPS; t++) begin
        weight = vt[k].w;
        tap(4'd1);
        if (k == 0 && t == 0) chk("busy_after_first_tap", busy, 1);
      end
      acc_cyc = cyc;
      wait_valid($sformatf("vec%0d", k), acc_cyc);
      chk($sformatf("vec%0d_lane0", k), out_data[15:0], vt[k].e0);
      chk($sformatf("vec%0d_lane1", k), out_data[31:16], vt[k].e1);
      chk($sformatf("vec%0d_lane_last", k), out_data[W-1 -: 16], vt[k].elast);
      chk($sformatf("vec%0d_busy_done", k), busy, 0);
      idle(1);
      chk($sformatf("vec%0d_pulse_width", k), out_valid, 0);
      idle(2);
    end

    // Reset in the middle of a window, asserted together with en.
    set_const(16'h0100); weight = 16'h0100; bias = 16'h0000;
    for (int t = 0; t < 13; t++) tap(4'd1);
    rst = 1'b1;
    tap(4'd1);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    v0 = vcount;
    for (int t = 0; t < TAPS; t++) tap(4'd1);
    idle(8);
    chk("midrst_valid_count", vcount - v0, 1);
    chk("midrst_value", vals[vals.size()-1], 16'h1900);

    // Back-to-back windows with gaps and ignored cur_state=2 taps.
    set_const(16'h0100); bias = 16'h0000;
    v0 = vcount;
    n0 = vals.size();
    window(16'h0100, 1'b1, 1'b0);
    window(16'h0200, 1'b1, 1'b0);
    idle(8);
    chk("b2b_valid_count", vcount - v0, 2);
    if (vals.size() >= n0 + 2) begin
      chk("b2b_first", vals[n0], 16'h1900);
      chk("b2b_second", vals[n0+1], 16'h3200);
    end else begin
      checks++;
      $display("FAIL b2b_values: got %0d results, required 2", vals.size() - n0);
    end

    // Randomized windows against the reference model.
    for (int k = 0; k < 8; k++) begin
      window(16'h0000, 1'b1, 1'b1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 4));
    end
    idle(8);
    chk("drain_empty", expq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/conv_accum.md
CONV_ACCUM -- requirements
Module: conv_accum

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 8, meaning fractional bits of the 16-bit signed fixed-point data, weight and bias.
REQ-002 SHALL have parameter TAPS, default 25, meaning products accumulated per output window (5x5 kernel).
REQ-003 SHALL have lane count `MAC_NUM from def_header.vh (112 for conv1); all wide ports are `MAC_NUM*16 bits.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  one kernel tap presented this cycle (same strobe that drives the upstream input buffer).
REQ-007 cur_state  input  4  layer state; taps accepted only when 4'd1 (conv1).
REQ-008 input_buf  input  `MAC_NUM*16  one signed activation per lane, lane i at bits [16i +: 16].
REQ-009 weight  input  16  signed kernel weight, broadcast to all lanes, aligned with en.
REQ-010 bias  input  16  signed bias, sampled on the final tap of a window.
REQ-011 out_data  output  `MAC_NUM*16  registered result per lane.
REQ-012 out_valid  output  1  one-cycle pulse, out_data valid.
REQ-013 busy  output  1  high from the first accepted tap until out_valid.

Function
REQ-014 SHALL accept a tap when en=1 and cur_state=4'd1; en with any other cur_state is ignored.
REQ-015 SHALL count accepted taps 0..TAPS-1 in tap_cnt; it wraps to 0 after tap TAPS-1.
REQ-016 SHALL compute per-lane product input_buf_i*weight as a 32-bit signed value, registered in pipeline stage 1.
REQ-017 SHALL hold per-lane 40-bit signed accumulators in stage 2.
REQ-018 SHALL load the accumulator with the product on tap 0 (no clear cycle) and add it on taps 1..TAPS-1.
REQ-019 SHALL, on the final tap, add bias<<FRAC_BITS (sign-extended) into the accumulator in the same stage-2 update.
REQ-020 SHALL form out_data_i = acc>>>FRAC_BITS (truncate toward minus infinity), saturated to [0x8000, 0x7FFF].
REQ-021 SHALL assert out_valid exactly 3 cycles after the clk edge that accepts the final tap (stage 1, stage 2, output register).
REQ-022 SHALL hold out_data stable until the next out_valid.
REQ-023 SHALL use FSM IDLE -> ACCUM on the first tap, ACCUM -> DRAIN after tap TAPS-1, and DRAIN -> IDLE when out_valid fires.
REQ-024 SHALL allow back-to-back windows: tap 0 of a new window accepted in DRAIN is processed; the pipeline keeps both windows separate, and the FSM goes DRAIN -> ACCUM.
REQ-025 SHALL tolerate en gaps of any length inside a window, with no timeout.
REQ-026 SHALL set busy = (state != IDLE).

Reset
REQ-027 SHALL on rst: state=IDLE, tap_cnt=0, accumulators, pipeline registers and out_data=0, out_valid=0, busy=0.
REQ-028 SHALL let rst mid-window discard the partial sum; no out_valid follows for that window.
REQ-029 SHALL give rst priority over a simultaneous en.

Configuration
REQ-030 SHALL honour macro CONV_ACCUM_RELU_EN: when defined, negative saturated results are replaced by 0x0000 before the output register; when undefined, signed results pass unchanged; latency is identical in both cases.

Verification
REQ-031 All lanes 0x0100, weight 0x0100, bias 0, 25 taps -> out_valid 3 cycles after the last tap, every lane 0x1900.
REQ-032 All lanes 0x7FFF, weight 0x7FFF, 25 taps -> every lane 0x7FFF (saturated); with lanes 0x8000 and macro undefined -> 0x8000.
REQ-033 Lane i = i<<8, weight 0xFF00 (-1.0), bias 0x0080 -> lane i = (-25i+0.5) in Q8.8; with CONV_ACCUM_RELU_EN every lane i>=1 reads 0x0000.
REQ-034 rst pulsed after tap 12, then 25 fresh taps of 0x0100*0x0100 -> exactly one out_valid, value 0x1900.
REQ-035 Two windows back-to-back (window 2 weight 0x0200) with random en gaps and cur_state=2 cycles inserted -> two out_valid pulses, values 0x1900 then 0x3200; the cur_state=2 taps are ignored.
